// File: rtl/johnson_decoder.sv
// Johnson-code receiver: legality check, successor check, binary/one-hot decode, lock FSM.
// Optional error counter enabled by defining JOHNSON_DEC_ERRCNT_EN; otherwise err_count is tied to 0.
module johnson_decoder #(
  parameter int N          = 4,
  parameter int LOCK_CNT   = 4,
  parameter int ALLOW_HOLD = 1,
  parameter int CW         = 8,
  localparam int IW        = $clog2(2*N),
  localparam int OW        = 2*N
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  code,
  output logic          out_valid,
  output logic [IW-1:0] idx,
  output logic [OW-1:0] onehot,
  output logic          illegal,
  output logic          step_err,
  output logic          locked,
  output logic [CW-1:0] err_count
);

  typedef enum logic [1:0] {UNLOCK, ACQ, LOCK} state_t;

  // {legal, index}: low half is k ones from the LSB, high half is m zeros from the LSB.
  function automatic logic [IW:0] decode(input logic [N-1:0] c);
    logic [N-1:0] pat;
    decode = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) pat[j] = (j < k);
      if (!c[N-1] && c == pat)  decode = {1'b1, IW'(k)};
      if (c[N-1]  && c == ~pat) decode = {1'b1, IW'(N + k)};
    end
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    good_q, good_d;
  logic [IW-1:0] prev_q, prev_d;
  logic          legal;
  logic [IW-1:0] dec_idx;
  logic [IW-1:0] succ_idx;
  logic          is_succ, is_hold, step_bad;

  logic          vld_p1;
  logic [IW-1:0] idx_p1;
  logic [OW-1:0] onehot_p1;
  logic          illegal_p1, step_err_p1;

  always_comb begin
    {legal, dec_idx} = decode(code);
    succ_idx = (prev_q == IW'(2*N - 1)) ? '0 : prev_q + 1'b1;
    is_succ  = (dec_idx == succ_idx);
    is_hold  = (dec_idx == prev_q);
    // In UNLOCK there is no history, so no sample can be a step error.
    step_bad = legal && (state_q != UNLOCK) && !(is_succ || (is_hold && ALLOW_HOLD != 0));
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    prev_d  = prev_q;
    if (in_valid) begin
      if (legal) prev_d = dec_idx;
      case (state_q)
        UNLOCK: begin
          if (legal) begin
            state_d = ACQ;
            good_d  = '0;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_d = UNLOCK;
            good_d  = '0;
          end else if (step_bad) begin
            good_d = '0;
          end else if (is_succ) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 == 8'(LOCK_CNT)) state_d = LOCK;
          end
        end
        LOCK: begin
          if (!legal) begin
            state_d = UNLOCK;
            good_d  = '0;
          end else if (step_bad) begin
            state_d = ACQ;
            good_d  = '0;
          end
        end
        default: state_d = UNLOCK;
      endcase
    end
  end

  // Stage p1: registered decode results and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCK;
      good_q      <= '0;
      prev_q      <= '0;
      vld_p1      <= 1'b0;
      idx_p1      <= '0;
      onehot_p1   <= OW'(1);
      illegal_p1  <= 1'b0;
      step_err_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      prev_q      <= prev_d;
      vld_p1      <= in_valid;
      illegal_p1  <= in_valid && !legal;
      step_err_p1 <= in_valid && step_bad;
      if (in_valid && legal) begin
        idx_p1    <= dec_idx;
        onehot_p1 <= OW'(1) << dec_idx;
      end
    end
  end

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [CW-1:0] err_cnt_p1;

  always_ff @(posedge clk) begin
    if (reset) err_cnt_p1 <= '0;
    else if (in_valid && (!legal || step_bad)) err_cnt_p1 <= sat_inc(err_cnt_p1);
  end

  assign err_count = err_cnt_p1;
`else
  assign err_count = '0;
`endif

  assign out_valid = vld_p1;
  assign idx       = idx_p1;
  assign onehot    = onehot_p1;
  assign illegal   = illegal_p1;
  assign step_err  = step_err_p1;
  assign locked    = (state_q == LOCK);

endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: two instances (hold allowed / hold forbidden) against a sequence-table model.
module tb_johnson_decoder;
  localparam int N  = 4;
  localparam int L  = 2*N;
  localparam int IW = 3;
  localparam int CW = 8;
  localparam int LOCK_CNT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [N-1:0] code = '0;

  logic          ov   [2];
  logic [IW-1:0] idx_o[2];
  logic [L-1:0]  oh_o [2];
  logic          ill_o[2];
  logic          se_o [2];
  logic          lk_o [2];
  logic [CW-1:0] ec_o [2];

  johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ALLOW_HOLD(1), .CW(CW)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
    .out_valid(ov[0]), .idx(idx_o[0]), .onehot(oh_o[0]), .illegal(ill_o[0]),
    .step_err(se_o[0]), .locked(lk_o[0]), .err_count(ec_o[0]));

  johnson_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ALLOW_HOLD(0), .CW(CW)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .code(code),
    .out_valid(ov[1]), .idx(idx_o[1]), .onehot(oh_o[1]), .illegal(ill_o[1]),
    .step_err(se_o[1]), .locked(lk_o[1]), .err_count(ec_o[1]));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Johnson sequence built by shifting left with the inverted MSB fed into bit 0
  logic [N-1:0] seq [L];

  // Model state per instance; state 0=unlock, 1=acquiring, 2=locked
  int hold_ok [2] = '{1, 0};
  int m_state [2];
  int m_good  [2];
  int m_prev  [2];
  int m_cnt   [2];
  bit e_vld [2];
  int e_idx [2];
  bit e_ill [2];
  bit e_se  [2];

  function automatic int lookup(input logic [N-1:0] c);
    lookup = -1;
    for (int i = 0; i < L; i++) if (seq[i] == c) lookup = i;
  endfunction

  task automatic check(input string nm, input int h, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", nm, h, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int h = 0; h < 2; h++) begin
      if (reset) begin
        m_state[h] = 0; m_good[h] = 0; m_prev[h] = 0; m_cnt[h] = 0;
        e_vld[h] = 0; e_idx[h] = 0; e_ill[h] = 0; e_se[h] = 0;
      end else if (!in_valid) begin
        e_vld[h] = 0; e_ill[h] = 0; e_se[h] = 0;
      end else begin
        int f;
        bit succ, hold;
        f = lookup(code);
        e_vld[h] = 1; e_ill[h] = 0; e_se[h] = 0;
        if (f < 0) begin
          e_ill[h] = 1;
          m_state[h] = 0;
          m_cnt[h]++;
        end else begin
          e_idx[h] = f;
          if (m_state[h] == 0) begin
            m_state[h] = 1; m_good[h] = 0;
          end else begin
            succ = (f == (m_prev[h] + 1) % L);
            hold = (f == m_prev[h]);
            if (!(succ || (hold && hold_ok[h] != 0))) begin
              e_se[h] = 1; m_cnt[h]++;
              m_state[h] = 1; m_good[h] = 0;
            end else if (succ && m_state[h] == 1) begin
              m_good[h]++;
              if (m_good[h] == LOCK_CNT) m_state[h] = 2;
            end
          end
          m_prev[h] = f;
        end
        if (m_cnt[h] > (1 << CW) - 1) m_cnt[h] = (1 << CW) - 1;
      end
    end
  end

  function automatic int exp_cnt(input int h);
`ifdef JOHNSON_DEC_ERRCNT_EN
    exp_cnt = m_cnt[h];
`else
    exp_cnt = 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int h = 0; h < 2; h++) begin
        check("out_valid", h, 32'(ov[h]), 32'(e_vld[h]));
        check("idx", h, 32'(idx_o[h]), 32'(e_idx[h]));
        check("onehot", h, 32'(oh_o[h]), 32'(1) << e_idx[h]);
        check("illegal", h, 32'(ill_o[h]), 32'(e_ill[h]));
        check("step_err", h, 32'(se_o[h]), 32'(e_se[h]));
        check("locked", h, 32'(lk_o[h]), 32'(m_state[h] == 2));
        check("err_count", h, 32'(ec_o[h]), 32'(exp_cnt(h)));
      end
    end
  end

  task automatic send(input logic [N-1:0] c);
    @(negedge clk); reset = 1'b0; in_valid = 1'b1; code = c;
  endtask

  task automatic idle();
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input int h, input logic [31:0] got, input logic [31:0] exp);
    check({"lit_", nm}, h, got, exp);
  endtask

  int sat_exp;
  int cur;
  int r;

  initial begin
`ifdef JOHNSON_DEC_ERRCNT_EN
    sat_exp = 255;
`else
    sat_exp = 0;
`endif
    seq[0] = '0;
    for (int i = 1; i < L; i++) seq[i] = {seq[i-1][N-2:0], ~seq[i-1][N-1]};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    for (int h = 0; h < 2; h++) begin
      lit("rst_vld", h, 32'(ov[h]), 0);
      lit("rst_idx", h, 32'(idx_o[h]), 0);
      lit("rst_onehot", h, 32'(oh_o[h]), 32'h01);
      lit("rst_locked", h, 32'(lk_o[h]), 0);
      lit("rst_cnt", h, 32'(ec_o[h]), 0);
    end

    // Acquire and lock
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0111);
    idle();
    lit("t1_idx3", 0, 32'(idx_o[0]), 3);
    lit("t1_nolock", 0, 32'(lk_o[0]), 0);
    send(4'b1111); idle();
    for (int h = 0; h < 2; h++) begin
      lit("t1_idx4", h, 32'(idx_o[h]), 4);
      lit("t1_onehot", h, 32'(oh_o[h]), 32'h10);
      lit("t1_locked", h, 32'(lk_o[h]), 1);
      lit("t1_cnt", h, 32'(ec_o[h]), 0);
    end

    // Wrap 7 -> 0
    send(4'b1110); send(4'b1100); send(4'b1000); send(4'b0000); idle();
    lit("t2_idx", 0, 32'(idx_o[0]), 0);
    lit("t2_se", 0, 32'(se_o[0]), 0);
    lit("t2_locked", 0, 32'(lk_o[0]), 1);

    // Step error from lock, then relock
    send(4'b0001); send(4'b0011); send(4'b1111); idle();
    for (int h = 0; h < 2; h++) begin
      lit("t3_se", h, 32'(se_o[h]), 1);
      lit("t3_locked", h, 32'(lk_o[h]), 0);
      lit("t3_cnt", h, 32'(ec_o[h]), sat_exp == 0 ? 0 : 1);
    end
    send(4'b1110); send(4'b1100); send(4'b1000); send(4'b0000); idle();
    lit("t3_relock", 0, 32'(lk_o[0]), 1);

    // Illegal code and hold behaviour
    send(4'b0101); idle();
    lit("t4_ill", 0, 32'(ill_o[0]), 1);
    lit("t4_idxhold", 0, 32'(idx_o[0]), 0);
    lit("t4_unlock", 0, 32'(lk_o[0]), 0);
    lit("t4_cnt", 0, 32'(ec_o[0]), sat_exp == 0 ? 0 : 2);
    send(4'b0011); send(4'b0011); idle();
    lit("t4_hold_ok", 0, 32'(se_o[0]), 0);
    lit("t4_hold_err", 1, 32'(se_o[1]), 1);
    lit("t4_cnt_h", 1, 32'(ec_o[1]), sat_exp == 0 ? 0 : 3);

    // Saturation
    for (int i = 0; i < 300; i++) send(4'b1010);
    idle();
    for (int h = 0; h < 2; h++) lit("t5_sat", h, 32'(ec_o[h]), 32'(sat_exp));

    // Reset together with in_valid while locked
    for (int i = 0; i < 5; i++) send(seq[i]);
    idle();
    lit("t6_prelock", 0, 32'(lk_o[0]), 1);
    @(negedge clk); reset = 1'b1; in_valid = 1'b1; code = 4'b1110;
    idle();
    for (int h = 0; h < 2; h++) begin
      lit("t6_vld", h, 32'(ov[h]), 0);
      lit("t6_locked", h, 32'(lk_o[h]), 0);
      lit("t6_idx", h, 32'(idx_o[h]), 0);
      lit("t6_cnt", h, 32'(ec_o[h]), 0);
    end
    send(4'b1100); idle();
    lit("t6_acq_se", 1, 32'(se_o[1]), 0);
    lit("t6_acq_idx", 1, 32'(idx_o[1]), 6);

    // Randomized traffic
    cur = 6;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        cur = (cur + 1) % L; send(seq[cur]);
      end else if (r < 72) begin
        send(seq[cur]);
      end else if (r < 80) begin
        cur = int'($urandom_range(0, L-1)); send(seq[cur]);
      end else if (r < 90) begin
        send(N'($urandom));
      end else if (r < 99) begin
        idle();
      end else begin
        @(negedge clk); reset = 1'b1; in_valid = 1'($urandom); code = N'($urandom);
      end
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
